// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation core.
package me_pkg;
  localparam int SAD_W    = 14;
  localparam int PIX_W    = 8;
  localparam int BLK      = 8;
  localparam int ROW_W    = 64;
  localparam int MV_MAX_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic signed [MV_MAX_W-1:0] x;
    logic signed [MV_MAX_W-1:0] y;
  } mv_t;
endpackage

// File: rtl/me_tag_pipe.sv
// Fixed-depth, never-stalling shift register carrying issue tags alongside buffer/SAD latency.
module me_tag_pipe #(
  parameter int W     = 8,
  parameter int DEPTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [W-1:0]              tag_in,
  output logic [DEPTH-1:0][W-1:0]   taps
);
  logic [DEPTH-1:0][W-1:0] pipe_d;
  logic [DEPTH-1:0][W-1:0] pipe_q;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign taps = pipe_q;
endmodule

// File: rtl/me_search_ctrl.sv
// Full-search scheduler: walks the +/-SR window in raster order, issues eight row
// reads per candidate, steers SAD accumulation and keeps the minimum-SAD vector.
module me_search_ctrl
  import me_pkg::*;
#(
  parameter int SR      = 4,
  parameter int RD_LAT  = 1,
  parameter int SAD_LAT = 2,
  parameter int MVW     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [SAD_W-1:0]        best_sad,
  output logic signed [MVW-1:0]   best_mvx,
  output logic signed [MVW-1:0]   best_mvy,
  output logic                    win_rd_en,
  input  logic                    win_ready,
  output logic signed [MVW-1:0]   win_mvx,
  output logic signed [MVW-1:0]   win_mvy,
  output logic [2:0]              win_row,
  output logic                    sad_vld,
  output logic                    sad_keep,
  input  logic [SAD_W-1:0]        sad_data
);
  localparam int DEPTH  = RD_LAT + SAD_LAT;
  localparam int TAG_W  = 3 + 2 * MVW;
  localparam int VLD_B  = TAG_W - 1;
  localparam int KEEP_B = TAG_W - 2;
  localparam int LAST_B = TAG_W - 3;
  localparam logic signed [MVW-1:0] SR_POS = MVW'(SR);
  localparam logic signed [MVW-1:0] SR_NEG = -SR_POS;

  state_t                 state_d, state_q;
  logic                   busy_d, busy_q, done_d, done_q;
  logic                   win_rd_en_d, win_rd_en_q;
  logic signed [MVW-1:0]  win_mvx_d, win_mvx_q, win_mvy_d, win_mvy_q;
  logic [2:0]             win_row_d, win_row_q;
  logic [SAD_W-1:0]       min_sad_d, min_sad_q, best_sad_d, best_sad_q;
  mv_t                    min_mv_d, min_mv_q, best_mv_d, best_mv_q;
  logic                   first_d, first_q;

  logic                        accept;
  logic [TAG_W-1:0]            tag_in;
  logic [DEPTH-1:0][TAG_W-1:0] taps;
  logic [TAG_W-1:0]            fin;
  logic signed [MVW-1:0]       fin_x, fin_y;
  logic                        fold, others_busy;

  assign accept = win_rd_en_q && win_ready;
  assign tag_in = {accept, win_row_q != 3'd0, win_row_q == 3'(BLK-1), win_mvx_q, win_mvy_q};

  me_tag_pipe #(.W(TAG_W), .DEPTH(DEPTH)) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_in (tag_in),
    .taps   (taps)
  );

  assign fin   = taps[DEPTH-1];
  assign fin_x = fin[2*MVW-1:MVW];
  assign fin_y = fin[MVW-1:0];
  assign fold  = fin[VLD_B] && fin[LAST_B];

  // Draining is complete once the final row-7 tag sits at the last tap alone.
  always_comb begin
    others_busy = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) others_busy = others_busy | taps[i][VLD_B];
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    win_rd_en_d = win_rd_en_q;
    win_mvx_d   = win_mvx_q;
    win_mvy_d   = win_mvy_q;
    win_row_d   = win_row_q;
    min_sad_d   = min_sad_q;
    min_mv_d    = min_mv_q;
    first_d     = first_q;
    best_sad_d  = best_sad_q;
    best_mv_d   = best_mv_q;

    // Strict less-than keeps the earlier raster candidate on ties.
    if (fold && (first_q || sad_data < min_sad_q)) begin
      min_sad_d  = sad_data;
      min_mv_d.x = MV_MAX_W'(fin_x);
      min_mv_d.y = MV_MAX_W'(fin_y);
      first_d    = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ISSUE;
          busy_d      = 1'b1;
          win_rd_en_d = 1'b1;
          win_mvx_d   = SR_NEG;
          win_mvy_d   = SR_NEG;
          win_row_d   = 3'd0;
          min_sad_d   = '1;
          first_d     = 1'b1;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          if (win_row_q == 3'(BLK-1)) begin
            win_row_d = 3'd0;
            if (win_mvx_q == SR_POS) begin
              if (win_mvy_q == SR_POS) begin
                state_d     = S_DRAIN;
                win_rd_en_d = 1'b0;
                win_mvx_d   = '0;
                win_mvy_d   = '0;
              end else begin
                win_mvx_d = SR_NEG;
                win_mvy_d = win_mvy_q + MVW'(1);
              end
            end else begin
              win_mvx_d = win_mvx_q + MVW'(1);
            end
          end else begin
            win_row_d = win_row_q + 3'd1;
          end
        end
      end
      S_DRAIN: begin
        if (fold && !others_busy) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          best_sad_d = min_sad_d;
          best_mv_d  = min_mv_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      win_rd_en_q <= 1'b0;
      win_mvx_q   <= '0;
      win_mvy_q   <= '0;
      win_row_q   <= '0;
      min_sad_q   <= '1;
      min_mv_q    <= '0;
      first_q     <= 1'b1;
      best_sad_q  <= '0;
      best_mv_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      win_rd_en_q <= win_rd_en_d;
      win_mvx_q   <= win_mvx_d;
      win_mvy_q   <= win_mvy_d;
      win_row_q   <= win_row_d;
      min_sad_q   <= min_sad_d;
      min_mv_q    <= min_mv_d;
      first_q     <= first_d;
      best_sad_q  <= best_sad_d;
      best_mv_q   <= best_mv_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign win_rd_en = win_rd_en_q;
  assign win_mvx   = win_mvx_q;
  assign win_mvy   = win_mvy_q;
  assign win_row   = win_row_q;
  assign sad_vld   = taps[RD_LAT-1][VLD_B];
  assign sad_keep  = taps[RD_LAT-1][KEEP_B];
  assign best_sad  = best_sad_q;
  assign best_mvx  = best_mv_q.x[MVW-1:0];
  assign best_mvy  = best_mv_q.y[MVW-1:0];
endmodule
